// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiply/MLA unit.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

endpackage : mul_pkg

// File: rtl/mul_if.sv
// Request/response bundle between pipeline control and the multiply unit.
interface mul_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             mla;
    logic             set_flags;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [3:0]       dest;

    logic             busy;
    logic             done;
    logic             we;
    logic [3:0]       wa;
    logic [WIDTH-1:0] result;
    logic             flags_we;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output start, mla, set_flags, flush, a, b, acc, dest,
        input  busy, done, we, wa, result, flags_we, flag_n, flag_z
    );

    modport slave (
        input  start, mla, set_flags, flush, a, b, acc, dest,
        output busy, done, we, wa, result, flags_we, flag_n, flag_z
    );

endinterface : mul_if

// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit: one multiplier bit per cycle, optional early
// termination once the remaining multiplier bits are zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH     = MUL_WIDTH,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    mul_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic [3:0]       wa_q, wa_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             flags_we_q, flags_we_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;

    logic [WIDTH-1:0] sum_c;
    logic             last_c;

    // One shift-add step; the carry out of the top bit is intentionally dropped.
    assign sum_c  = p_q + (b_q[0] ? a_q : '0);
    assign last_c = (cnt_q == CNT_LAST) || (EARLY_OUT && ((b_q >> 1) == '0));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        wa_d       = wa_q;
        result_d   = result_q;
        flag_n_d   = flag_n_q;
        flag_z_d   = flag_z_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    p_d     = bus.mla ? bus.acc : '0;
                    wa_d    = bus.dest;
                    s_d     = bus.set_flags;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Flush wins over completion: no write, result untouched.
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    p_d   = sum_c;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        state_d  = DONE;
                        result_d = sum_c;
                        flag_n_d = sum_c[WIDTH-1];
                        flag_z_d = (sum_c == '0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        flags_we_d = (state_d == DONE) && s_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            wa_q       <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flags_we_q <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            wa_q       <= wa_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flags_we_q <= flags_we_d;
            flag_n_q   <= flag_n_d;
            flag_z_q   <= flag_z_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.we       = done_q;
    assign bus.wa       = wa_q;
    assign bus.result   = result_q;
    assign bus.flags_we = flags_we_q;
    assign bus.flag_n   = flag_n_q;
    assign bus.flag_z   = flag_z_q;

endmodule : mul_unit
